// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter for the register-file write port, with a soft-clear sweep
module rf_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [NUM_REQ-1:0]             REQ_VALID,
  output logic [NUM_REQ-1:0]             REQ_READY,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  REQ_ADDRESS,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  REQ_DATA,
  input  logic                           CLEAR_START,
  output logic                           CLEAR_BUSY,
  output logic [GW-1:0]                  GRANT_ID,
  output logic                           WRITE_ENABLE,
  output logic [ADDR_WIDTH-1:0]          WRITE_ADDRESS,
  output logic [DATA_WIDTH-1:0]          WRITE_DATA
);

  typedef enum logic {RUN, CLEAR} state_t;

  localparam logic [GW-1:0]       LAST_INIT = GW'(NUM_REQ - 1);
  // Sweep counter is one bit wider than an address so the terminal compare never wraps
  localparam logic [ADDR_WIDTH:0] SWEEP_END = (ADDR_WIDTH + 1)'((1 << ADDR_WIDTH) - 1);

  state_t                state, state_next;
  logic [GW-1:0]         last;
  logic [ADDR_WIDTH:0]   sweep;
  logic                  grant_any;
  logic [GW-1:0]         grant_idx;
  logic [GW-1:0]         idx;
  logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_addr[i] = REQ_ADDRESS[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_data[i] = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (CLEAR_START) state_next = CLEAR;
      CLEAR:   if (sweep == SWEEP_END) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Grant goes to the first valid requester after the last one served
  always_comb begin
    REQ_READY  = '0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    idx        = '0;
    CLEAR_BUSY = (state == CLEAR);
    if (state == RUN && !CLEAR_START && !RESET) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = GW'((int'(last) + k) % NUM_REQ);
        if (!grant_any && REQ_VALID[idx]) begin
          grant_any = 1'b1;
          grant_idx = idx;
        end
      end
      if (grant_any) REQ_READY[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      WRITE_ENABLE  <= 1'b0;
      WRITE_ADDRESS <= '0;
      WRITE_DATA    <= '0;
      GRANT_ID      <= '0;
      last          <= LAST_INIT;
      sweep         <= '0;
    end else begin
      case (state)
        RUN: begin
          if (CLEAR_START) begin
            WRITE_ENABLE <= 1'b0;
            sweep        <= (ADDR_WIDTH + 1)'(1);
          end else if (grant_any) begin
            // Address 0 is hard-wired zero: accept the write but keep it off the port
            WRITE_ENABLE  <= (req_addr[grant_idx] != '0);
            WRITE_ADDRESS <= req_addr[grant_idx];
            WRITE_DATA    <= req_data[grant_idx];
            GRANT_ID      <= grant_idx;
            last          <= grant_idx;
          end else begin
            WRITE_ENABLE <= 1'b0;
          end
        end
        CLEAR: begin
          WRITE_ENABLE  <= 1'b1;
          WRITE_ADDRESS <= sweep[ADDR_WIDTH-1:0];
          WRITE_DATA    <= '0;
          sweep         <= sweep + 1'b1;
        end
        default: WRITE_ENABLE <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;
  localparam int N = 3, DW = 32, AW = 5;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic [N-1:0]    REQ_VALID = '0;
  logic [N-1:0]    REQ_READY;
  logic [AW-1:0]   req_a [N];
  logic [DW-1:0]   req_d [N];
  logic [N*AW-1:0] REQ_ADDRESS;
  logic [N*DW-1:0] REQ_DATA;
  logic            CLEAR_START = 1'b0;
  logic            CLEAR_BUSY;
  logic [1:0]      GRANT_ID;
  logic            WRITE_ENABLE;
  logic [AW-1:0]   WRITE_ADDRESS;
  logic [DW-1:0]   WRITE_DATA;

  assign REQ_ADDRESS = {req_a[2], req_a[1], req_a[0]};
  assign REQ_DATA    = {req_d[2], req_d[1], req_d[0]};

  rf_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDRESS(REQ_ADDRESS), .REQ_DATA(REQ_DATA), .CLEAR_START(CLEAR_START),
    .CLEAR_BUSY(CLEAR_BUSY), .GRANT_ID(GRANT_ID), .WRITE_ENABLE(WRITE_ENABLE),
    .WRITE_ADDRESS(WRITE_ADDRESS), .WRITE_DATA(WRITE_DATA)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: last-served index, sweep progress and the expected write port
  int            m_last;
  bit            m_clear;
  int            m_sweep;
  logic          m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  logic [1:0]    m_gid;

  function automatic int exp_grant();
    if (m_clear || CLEAR_START) return -1;
    for (int k = 1; k <= N; k++)
      if (REQ_VALID[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_last = N - 1; m_clear = 0; m_sweep = 0;
    m_we = 0; m_wa = '0; m_wd = '0; m_gid = '0;
  endtask

  task automatic tick(output int g);
    g = exp_grant();
    @(posedge CLK);
    if (m_clear) begin
      m_we = 1; m_wa = AW'(m_sweep); m_wd = '0;
      if (m_sweep == (1 << AW) - 1) m_clear = 0;
      else m_sweep++;
    end else if (CLEAR_START) begin
      m_clear = 1; m_sweep = 1; m_we = 0;
    end else if (g >= 0) begin
      m_we = (req_a[g] != '0); m_wa = req_a[g]; m_wd = req_d[g];
      m_gid = 2'(g); m_last = g;
    end else begin
      m_we = 0;
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1; REQ_VALID = '0; CLEAR_START = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    RESET = 0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RESET = 1; REQ_VALID = '1; CLEAR_START = 0;
    for (int i = 0; i < N; i++) begin req_a[i] = AW'(i + 1); req_d[i] = DW'(i); end
    model_reset();
    #1;
    n_cmp++;
    if (REQ_READY !== 3'b000) begin n_bad++; $display("FAIL reset_ready: got %b want 000", REQ_READY); end
    n_cmp++;
    if ({WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA, GRANT_ID} !== '0) begin
      n_bad++; $display("FAIL reset_port: got we=%b a=%0d d=%h g=%0d want all 0", WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA, GRANT_ID);
    end
    n_cmp++;
    if (CLEAR_BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", CLEAR_BUSY); end
    @(negedge CLK);
    RESET = 0;
    #1;
    n_cmp++;
    if (REQ_READY !== 3'b001) begin n_bad++; $display("FAIL reset_first_grant: got %b want 001", REQ_READY); end
    REQ_VALID = '0;
  endtask

  task automatic test_single_write();
    int g;
    @(negedge CLK);
    req_a[0] = 5; req_d[0] = 32'hDEADBEEF; REQ_VALID = 3'b001;
    #1;
    n_cmp++;
    if (REQ_READY !== 3'b001) begin n_bad++; $display("FAIL single_ready: got %b want 001", REQ_READY); end
    tick(g);
    REQ_VALID = '0;
    n_cmp++;
    if ({WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA, GRANT_ID} !== {1'b1, 5'd5, 32'hDEADBEEF, 2'd0}) begin
      n_bad++; $display("FAIL single_write: got we=%b a=%0d d=%h g=%0d want 1/5/deadbeef/0", WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA, GRANT_ID);
    end
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    for (int i = 0; i < N; i++) begin req_a[i] = AW'(i + 7); req_d[i] = $urandom; end
    REQ_VALID = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_cmp++;
      if (REQ_READY !== onehot(c % 3)) begin n_bad++; $display("FAIL rr_ready[%0d]: got %b want %b", c, REQ_READY, onehot(c % 3)); end
      tick(g);
      n_cmp++;
      if ({WRITE_ENABLE, GRANT_ID, WRITE_ADDRESS, WRITE_DATA} !== {1'b1, 2'(c % 3), req_a[c % 3], req_d[c % 3]}) begin
        n_bad++; $display("FAIL rr_write[%0d]: got we=%b g=%0d a=%0d want we=1 g=%0d a=%0d", c, WRITE_ENABLE, GRANT_ID, WRITE_ADDRESS, c % 3, req_a[c % 3]);
      end
    end
    REQ_VALID = '0;
  endtask

  task automatic test_addr_zero();
    int g;
    req_a[1] = 0; req_d[1] = 32'h1234; REQ_VALID = 3'b010;
    #1;
    n_cmp++;
    if (REQ_READY !== 3'b010) begin n_bad++; $display("FAIL a0_ready: got %b want 010", REQ_READY); end
    tick(g);
    n_cmp++;
    if ({WRITE_ENABLE, GRANT_ID} !== {1'b0, 2'd1}) begin
      n_bad++; $display("FAIL a0_drop: got we=%b g=%0d want we=0 g=1", WRITE_ENABLE, GRANT_ID);
    end
    REQ_VALID = 3'b111;
    #1;
    n_cmp++;
    if (REQ_READY !== 3'b100) begin n_bad++; $display("FAIL a0_next: got %b want 100", REQ_READY); end
    tick(g);
    REQ_VALID = '0;
    n_cmp++;
    if ({WRITE_ENABLE, GRANT_ID} !== {1'b1, 2'd2}) begin
      n_bad++; $display("FAIL a0_after: got we=%b g=%0d want we=1 g=2", WRITE_ENABLE, GRANT_ID);
    end
  endtask

  task automatic test_soft_clear();
    int g;
    req_a[2] = 9; req_d[2] = 32'hCAFE0002; REQ_VALID = 3'b100; CLEAR_START = 1;
    #1;
    n_cmp++;
    if (REQ_READY !== 3'b000) begin n_bad++; $display("FAIL clr_start_ready: got %b want 000", REQ_READY); end
    tick(g);
    CLEAR_START = 0;
    for (int n = 1; n < 32; n++) begin
      if (n == 5) CLEAR_START = 1;
      #1;
      n_cmp++;
      if ({CLEAR_BUSY, REQ_READY} !== 4'b1000) begin
        n_bad++; $display("FAIL clr_busy[%0d]: got busy=%b ready=%b want 1/000", n, CLEAR_BUSY, REQ_READY);
      end
      tick(g);
      CLEAR_START = 0;
      n_cmp++;
      if ({WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA} !== {1'b1, AW'(n), 32'h0}) begin
        n_bad++; $display("FAIL clr_write[%0d]: got we=%b a=%0d d=%h want 1/%0d/0", n, WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA, n);
      end
    end
    #1;
    n_cmp++;
    if ({CLEAR_BUSY, REQ_READY} !== 4'b0100) begin
      n_bad++; $display("FAIL clr_resume: got busy=%b ready=%b want 0/100", CLEAR_BUSY, REQ_READY);
    end
    tick(g);
    REQ_VALID = '0;
    n_cmp++;
    if ({WRITE_ENABLE, GRANT_ID, WRITE_ADDRESS} !== {1'b1, 2'd2, 5'd9}) begin
      n_bad++; $display("FAIL clr_after: got we=%b g=%0d a=%0d want 1/2/9", WRITE_ENABLE, GRANT_ID, WRITE_ADDRESS);
    end
  endtask

  task automatic test_clear_abort();
    int g;
    CLEAR_START = 1;
    tick(g);
    CLEAR_START = 0;
    for (int n = 1; n <= 10; n++) tick(g);
    n_cmp++;
    if ({WRITE_ENABLE, WRITE_ADDRESS} !== {1'b1, 5'd10}) begin
      n_bad++; $display("FAIL abort_pre: got we=%b a=%0d want 1/10", WRITE_ENABLE, WRITE_ADDRESS);
    end
    #2 RESET = 1;
    model_reset();
    #1;
    n_cmp++;
    if ({WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA, GRANT_ID, CLEAR_BUSY} !== '0) begin
      n_bad++; $display("FAIL abort_zero: got we=%b a=%0d d=%h g=%0d busy=%b want all 0", WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA, GRANT_ID, CLEAR_BUSY);
    end
    @(negedge CLK);
    RESET = 0;
    for (int i = 0; i < N; i++) req_a[i] = AW'(i + 20);
    REQ_VALID = 3'b111;
    #1;
    n_cmp++;
    if ({CLEAR_BUSY, REQ_READY} !== 4'b0001) begin
      n_bad++; $display("FAIL abort_resume: got busy=%b ready=%b want 0/001", CLEAR_BUSY, REQ_READY);
    end
    tick(g);
    REQ_VALID = '0;
    n_cmp++;
    if ({WRITE_ENABLE, GRANT_ID} !== {1'b1, 2'd0}) begin
      n_bad++; $display("FAIL abort_write: got we=%b g=%0d want 1/0", WRITE_ENABLE, GRANT_ID);
    end
  endtask

  task automatic test_back_to_back();
    int g;
    req_a[1] = 11; req_a[2] = 12; REQ_VALID = 3'b010;
    #1;
    n_cmp++;
    if (REQ_READY !== 3'b010) begin n_bad++; $display("FAIL b2b_ready1: got %b want 010", REQ_READY); end
    tick(g);
    REQ_VALID = 3'b100;
    #1;
    n_cmp++;
    if ({REQ_READY, WRITE_ENABLE, GRANT_ID, WRITE_ADDRESS} !== {3'b100, 1'b1, 2'd1, 5'd11}) begin
      n_bad++; $display("FAIL b2b_first: got ready=%b we=%b g=%0d a=%0d want 100/1/1/11", REQ_READY, WRITE_ENABLE, GRANT_ID, WRITE_ADDRESS);
    end
    tick(g);
    REQ_VALID = '0;
    n_cmp++;
    if ({WRITE_ENABLE, GRANT_ID, WRITE_ADDRESS} !== {1'b1, 2'd2, 5'd12}) begin
      n_bad++; $display("FAIL b2b_second: got we=%b g=%0d a=%0d want 1/2/12", WRITE_ENABLE, GRANT_ID, WRITE_ADDRESS);
    end
  endtask

  task automatic test_random();
    int g;
    logic [N-1:0] want_ready;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!REQ_VALID[i] && $urandom_range(0, 1) == 1) begin
          req_a[i] = AW'($urandom_range(0, 31)); req_d[i] = $urandom; REQ_VALID[i] = 1'b1;
        end
      end
      CLEAR_START = ($urandom_range(0, 59) == 0);
      #1;
      want_ready = onehot(exp_grant());
      n_cmp++;
      if ({REQ_READY, CLEAR_BUSY} !== {want_ready, m_clear}) begin
        n_bad++; $display("FAIL rnd_ready[%0d]: got ready=%b busy=%b want %b/%b", c, REQ_READY, CLEAR_BUSY, want_ready, m_clear);
      end
      tick(g);
      if (g >= 0) REQ_VALID[g] = 1'b0;
      CLEAR_START = 0;
      n_cmp++;
      if ({WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA, GRANT_ID} !== {m_we, m_wa, m_wd, m_gid}) begin
        n_bad++; $display("FAIL rnd_port[%0d]: got we=%b a=%0d d=%h g=%0d want %b/%0d/%h/%0d", c, WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA, GRANT_ID, m_we, m_wa, m_wd, m_gid);
      end
    end
    REQ_VALID = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin req_a[i] = '0; req_d[i] = '0; end
    model_reset();
    test_reset();
    test_single_write();
    test_round_robin();
    test_addr_zero();
    test_soft_clear();
    test_clear_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ writeback sources, e.g. ALU result, load return and debug/host.
- Arbitration is round-robin; each source uses a valid/ready handshake.
- Also provides a "soft clear" sequencer that zeroes registers 1..31 through the normal write port, one register per cycle, without asserting RESET.
- Sits between the writeback stage and the register file; drives its WRITE_ENABLE / WRITE_ADDRESS / WRITE_DATA inputs directly.

Parameters:
- NUM_REQ, 3, number of write requesters (2..8).
- DATA_WIDTH, 32, write data width.
- ADDR_WIDTH, 5, register address width; the register count is 2**ADDR_WIDTH.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQ_VALID  input  NUM_REQ  bit i: requester i has a write pending.
- REQ_READY  output  NUM_REQ  bit i: requester i is accepted this cycle.
- REQ_ADDRESS  input  NUM_REQ*ADDR_WIDTH  flattened; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- REQ_DATA  input  NUM_REQ*DATA_WIDTH  flattened; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- CLEAR_START  input  1  single-cycle pulse requesting a soft clear.
- CLEAR_BUSY  output  1  high while the clear sweep is running.
- GRANT_ID  output  clog2(NUM_REQ)  index of the requester whose write is on the port this cycle.
- WRITE_ENABLE  output  1  register-file write enable (registered).
- WRITE_ADDRESS  output  ADDR_WIDTH  register-file write address (registered).
- WRITE_DATA  output  DATA_WIDTH  register-file write data (registered).

Behaviour:
- Reset values:
  - State = RUN; round-robin pointer LAST = NUM_REQ-1, so requester 0 wins first.
  - WRITE_ENABLE = 0, WRITE_ADDRESS = 0, WRITE_DATA = 0, GRANT_ID = 0.
  - CLEAR_BUSY = 0, REQ_READY = 0.
- FSM has two states: RUN and CLEAR.
- RUN, arbitration:
  - REQ_READY is combinational: exactly one bit is high, belonging to the first valid requester found scanning LAST+1, LAST+2, ... modulo NUM_REQ.
  - All REQ_READY bits are 0 when no REQ_VALID bit is set, or when CLEAR_START = 1 in that cycle.
  - A transfer occurs on a cycle where REQ_VALID[i] and REQ_READY[i] are both high.
- Requester rules:
  - A requester holds VALID, ADDRESS and DATA stable until it sees READY.
  - VALID must not depend on READY.
- On a transfer from requester i:
  - Next edge: WRITE_ADDRESS = addr_i, WRITE_DATA = data_i, GRANT_ID = i, LAST = i.
  - WRITE_ENABLE = 1 if addr_i != 0, else 0. Address-0 writes are accepted and dropped; LAST is still updated.
  - Latency from request acceptance to the write appearing on the port is 1 cycle.
- With no transfer, WRITE_ENABLE = 0 next cycle. WRITE_ADDRESS, WRITE_DATA and GRANT_ID hold their values.
- Throughput is one write per cycle, back-to-back. A requester that keeps VALID high receives at most one grant in every NUM_REQ consecutive grants while other requesters are pending.
- RUN to CLEAR:
  - CLEAR_START = 1 in RUN takes priority over all requests in that cycle; no grant is issued.
  - Next edge: state = CLEAR, sweep counter = 1, CLEAR_BUSY = 1.
- CLEAR state:
  - Each cycle registers WRITE_ENABLE = 1, WRITE_ADDRESS = counter, WRITE_DATA = 0, then increments the counter.
  - The sweep covers addresses 1 .. 2**ADDR_WIDTH-1. Address 0 is never written.
  - The final address is 31 with defaults; on the edge that registers it, state returns to RUN and CLEAR_BUSY falls.
  - The write port therefore shows 31 consecutive zero writes to addresses 1..31, starting one cycle after CLEAR_BUSY rises.
  - REQ_READY = 0 throughout CLEAR; pending requesters wait with VALID held.
  - CLEAR_START during CLEAR is ignored and not queued.
- Arbitration resumes in the first RUN cycle after the sweep, using the LAST value from before the clear.
- RESET asserted mid-sweep or mid-write aborts immediately: all outputs take their reset values, state = RUN, and registers already cleared stay cleared.
- Width rules:
  - Sweep counter is ADDR_WIDTH+1 bits so the terminal compare does not wrap.
  - GRANT_ID width is clog2(NUM_REQ), with a minimum of 1.

Test Plan:
- Single write: after reset, REQ_VALID=001, addr0=5, data0=0xDEADBEEF -> REQ_READY=001 in the same cycle; next cycle WRITE_ENABLE=1, WRITE_ADDRESS=5, WRITE_DATA=0xDEADBEEF, GRANT_ID=0.
- Round-robin: all three requesters held valid for 6 cycles -> grant order 0,1,2,0,1,2; WRITE_ENABLE high on 6 consecutive cycles.
- Address 0: requester 1 sends addr=0, data=0x1234 -> REQ_READY[1]=1; next cycle WRITE_ENABLE=0; the following arbitration starts at requester 2.
- Soft clear: pulse CLEAR_START with requester 2 valid in the same cycle -> no ready; CLEAR_BUSY high for 31 cycles; writes to addresses 1..31 with data 0; requester 2 is granted in the first cycle after CLEAR_BUSY falls.
- Clear abort: assert RESET at sweep address 10 -> outputs zero immediately; after release, state = RUN and requester 0 has priority.
- Back-to-back: alternate valids 010 then 100 on consecutive cycles -> writes with GRANT_ID 1 then 2, no bubble on WRITE_ENABLE.
